// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
//   uart_parity_e    parity mode carried on parity_i (codes 5-7 decode to none)
//   uart_tx_state_e  transmitter FSM states
//   uart_parity_decode / uart_clamp_data_bits / uart_parity_bit
//                    normalise raw configuration inputs and compute the parity bit
package uart_pkg;

    typedef enum logic [2:0] {
        e_parity_none  = 3'd0,
        e_parity_even  = 3'd1,
        e_parity_odd   = 3'd2,
        e_parity_mark  = 3'd3,
        e_parity_space = 3'd4
    } uart_parity_e;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
        e_parity,
        e_stop,
        e_break,
        e_break_guard
    } uart_tx_state_e;

    localparam logic [3:0] uart_min_data_bits_lp = 4'd5;
    localparam logic [3:0] uart_max_data_bits_lp = 4'd9;

    // Unused encodings fall back to no parity.
    function automatic uart_parity_e uart_parity_decode(input logic [2:0] code);
        uart_parity_e mode;
        case (code)
            3'd1:    mode = e_parity_even;
            3'd2:    mode = e_parity_odd;
            3'd3:    mode = e_parity_mark;
            3'd4:    mode = e_parity_space;
            default: mode = e_parity_none;
        endcase
        return mode;
    endfunction

    function automatic logic [3:0] uart_clamp_data_bits(input logic [3:0] n);
        logic [3:0] r;
        if (n < uart_min_data_bits_lp)      r = uart_min_data_bits_lp;
        else if (n > uart_max_data_bits_lp) r = uart_max_data_bits_lp;
        else                                r = n;
        return r;
    endfunction

    // Parity covers only the nbits data bits actually sent.
    function automatic logic uart_parity_bit(input uart_parity_e mode,
                                             input logic [8:0]   data,
                                             input logic [3:0]   nbits);
        logic x;
        logic p;
        x = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (4'(i) < nbits) x = x ^ data[i];
        end
        case (mode)
            e_parity_even: p = x;
            e_parity_odd:  p = ~x;
            e_parity_mark: p = 1'b1;
            default:       p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small single-clock FIFO with valid/ready enqueue and valid/yumi dequeue.
//   clk_i, reset_i  clock and synchronous active-high reset (flushes contents)
//   v_i, data_i     enqueue request and word; accepted when v_i & ready_o
//   ready_o         not full; independent of a same-cycle dequeue
//   v_o, data_o     head word valid (non-empty) and head word
//   yumi_i          consume head word (only meaningful while v_o)
//   count_o         number of words held
module bsg_fifo_1r1w_small #(
    parameter  int els_p          = 16,
    parameter  int width_p        = 9,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = next_ptr(wr_ptr_q);
        if (deq) rd_ptr_d = next_ptr(rd_ptr_q);
        case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter with runtime frame format.
//   clk_i, reset_i   clock and synchronous active-high reset
//   div_i            clocks per bit (0 behaves as 1)
//   data_bits_i      data bits per frame, clamped to 5..9
//   parity_i         uart_parity_e code (5-7 -> none)
//   stop_bits_i      0 = one stop bit, 1 = two stop bits
//   break_i          level request to hold the line low
//   data_i, v_i      word to send and its valid; accepted when v_i & ready_and_o
//   ready_and_o      FIFO not full (low during reset)
//   tx_o             registered serial line, idle high
//   busy_o           frame/break activity or queued words
//   done_o           one-cycle pulse per completed frame
//   fifo_count_o     words waiting in the FIFO
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter  int fifo_els_p      = 16,
    parameter  int max_data_bits_p = 9,
    parameter  int div_width_p     = 16,
    localparam int count_width_lp  = $clog2(fifo_els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [div_width_p-1:0]     div_i,
    input  logic [3:0]                 data_bits_i,
    input  logic [2:0]                 parity_i,
    input  logic                       stop_bits_i,
    input  logic                       break_i,
    input  logic [max_data_bits_p-1:0] data_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [count_width_lp-1:0]  fifo_count_o
);

    logic                       fifo_ready, fifo_v, fifo_yumi;
    logic [max_data_bits_p-1:0] fifo_data;

    bsg_fifo_1r1w_small #(
        .els_p   (fifo_els_p),
        .width_p (max_data_bits_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi),
        .count_o (fifo_count_o)
    );

    uart_tx_state_e             state_q, state_d;
    logic                       tx_q, tx_d;
    logic                       done_q, done_d;
    logic [div_width_p-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [max_data_bits_p-1:0] shift_q, shift_d;
    logic [div_width_p-1:0]     div_q, div_d;
    logic                       stop2_q, stop2_d;
    logic                       parity_en_q, parity_en_d;
    logic                       parity_bit_q, parity_bit_d;

    logic [div_width_p-1:0]     div_eff;
    logic [3:0]                 nbits_eff;
    uart_parity_e               parity_eff;
    logic                       launch;
    logic                       launch_ok;
    logic                       bit_end;

    assign div_eff    = (div_i == '0) ? div_width_p'(1) : div_i;
    assign nbits_eff  = uart_clamp_data_bits(data_bits_i);
    assign parity_eff = uart_parity_decode(parity_i);
    assign launch_ok  = fifo_v & ~break_i;
    assign bit_end    = (clk_cnt_q == '0);

    assign ready_and_o = fifo_ready & ~reset_i;
    assign tx_o        = tx_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != e_idle) | fifo_v;

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        done_d       = 1'b0;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        div_d        = div_q;
        stop2_d      = stop2_q;
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
        fifo_yumi    = 1'b0;
        launch       = 1'b0;

        // Within a bit period only the counter moves; state changes happen at bit_end.
        if (!bit_end && state_q != e_idle && state_q != e_break) begin
            clk_cnt_d = clk_cnt_q - div_width_p'(1);
        end

        case (state_q)
            e_idle: begin
                tx_d = 1'b1;
                if (break_i) begin
                    state_d = e_break;
                    tx_d    = 1'b0;
                    div_d   = div_eff;
                end else if (fifo_v) begin
                    launch = 1'b1;
                end
            end

            e_start: begin
                if (bit_end) begin
                    state_d   = e_data;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    clk_cnt_d = div_q - div_width_p'(1);
                end
            end

            e_data: begin
                if (bit_end) begin
                    clk_cnt_d = div_q - div_width_p'(1);
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (parity_en_q) begin
                        state_d = e_parity;
                        tx_d    = parity_bit_q;
                    end else begin
                        state_d   = e_stop;
                        tx_d      = 1'b1;
                        bit_cnt_d = {3'b000, stop2_q};
                    end
                end
            end

            e_parity: begin
                if (bit_end) begin
                    state_d   = e_stop;
                    tx_d      = 1'b1;
                    bit_cnt_d = {3'b000, stop2_q};
                    clk_cnt_d = div_q - div_width_p'(1);
                end
            end

            e_stop: begin
                if (bit_end) begin
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        clk_cnt_d = div_q - div_width_p'(1);
                    end else begin
                        done_d = 1'b1;
                        // Chaining straight into the next start bit keeps frames gap-free.
                        if (launch_ok) launch = 1'b1;
                        else           state_d = e_idle;
                    end
                end
            end

            e_break: begin
                tx_d = 1'b0;
                if (!break_i) begin
                    state_d   = e_break_guard;
                    tx_d      = 1'b1;
                    clk_cnt_d = div_q - div_width_p'(1);
                end
            end

            e_break_guard: begin
                if (bit_end) begin
                    // Passing through idle would stretch the mark by a cycle, so launch directly.
                    if (launch_ok) launch = 1'b1;
                    else           state_d = e_idle;
                end
            end

            default: begin
                state_d = e_idle;
                tx_d    = 1'b1;
            end
        endcase

        // Frame launch: pop the head word and freeze the current configuration for the whole frame.
        if (launch) begin
            fifo_yumi    = 1'b1;
            state_d      = e_start;
            tx_d         = 1'b0;
            div_d        = div_eff;
            clk_cnt_d    = div_eff - div_width_p'(1);
            bit_cnt_d    = nbits_eff - 4'd1;
            shift_d      = fifo_data;
            stop2_d      = stop_bits_i;
            parity_en_d  = (parity_eff != e_parity_none);
            parity_bit_d = uart_parity_bit(parity_eff, fifo_data, nbits_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_idle;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            div_q        <= div_width_p'(1);
            stop2_q      <= 1'b0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            div_q        <= div_d;
            stop2_q      <= stop2_d;
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: directed frame formats, randomized frames
// with mid-frame configuration churn, line break, FIFO fill with back-to-back drain,
// and reset during a frame. Expected line waveforms come from a bit-list model.
`timescale 1ns/1ps
module tb_uart_tx_stream;

    localparam int fifo_els_lp = 16;
    localparam int cw_lp       = $clog2(fifo_els_lp + 1);

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [15:0]      div_i;
    logic [3:0]       data_bits_i;
    logic [2:0]       parity_i;
    logic             stop_bits_i;
    logic             break_i;
    logic [8:0]       data_i;
    logic             v_i;
    logic             ready_and_o;
    logic             tx_o;
    logic             busy_o;
    logic             done_o;
    logic [cw_lp-1:0] fifo_count_o;

    uart_tx_stream #(
        .fifo_els_p      (fifo_els_lp),
        .max_data_bits_p (9),
        .div_width_p     (16)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .div_i        (div_i),
        .data_bits_i  (data_bits_i),
        .parity_i     (parity_i),
        .stop_bits_i  (stop_bits_i),
        .break_i      (break_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_and_o  (ready_and_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle line level, done pulse and FIFO count (-1 = not checked).
    bit exp_tx[$];
    bit exp_done[$];
    int exp_cnt[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: a frame is a list of bit levels, each held for div cycles.
    task automatic append_frame(input int div, input int nbits_raw, input int par_raw,
                                input bit stop2, input int data, input bit first, input int cnt);
        int d, n, ones;
        bit bits[$];
        d = (div == 0) ? 1 : div;
        n = (nbits_raw < 5) ? 5 : ((nbits_raw > 9) ? 9 : nbits_raw);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(((data >> i) & 1) != 0);
            ones += (data >> i) & 1;
        end
        case (par_raw)
            1: bits.push_back((ones % 2) == 1);
            2: bits.push_back((ones % 2) == 0);
            3: bits.push_back(1'b1);
            4: bits.push_back(1'b0);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < d; c++) begin
                exp_tx.push_back(bits[b]);
                exp_done.push_back((b == 0 && c == 0) ? !first : 1'b0);
                exp_cnt.push_back((b == 0 && c == 0) ? cnt : -1);
            end
        end
    endtask

    task automatic set_cfg(input int div, input int nbits, input int par, input bit stop2);
        div_i       = 16'(div);
        data_bits_i = 4'(nbits);
        parity_i    = 3'(par);
        stop_bits_i = stop2;
    endtask

    task automatic push(input string tag, input int data);
        int k;
        v_i    = 1'b1;
        data_i = 9'(data);
        k = 0;
        while (ready_and_o !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check({tag, " push accepted"}, 32'(ready_and_o), 32'd1);
        tick();
        v_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (tx_o !== 1'b0 && k < 64) begin
            tick();
            k++;
        end
        check({tag, " start bit seen"}, 32'(tx_o), 32'd0);
    endtask

    // Current sample is the first cycle of the expected stream.
    task automatic compare_stream(input string tag, input bit scramble);
        int i;
        i = 0;
        while (exp_tx.size() > 0) begin
            if (i > 0) tick();
            check($sformatf("%s tx cyc %0d", tag, i), 32'(tx_o), 32'(exp_tx[0]));
            check($sformatf("%s done cyc %0d", tag, i), 32'(done_o), 32'(exp_done[0]));
            if (exp_cnt[0] >= 0)
                check($sformatf("%s count cyc %0d", tag, i), 32'(fifo_count_o), 32'(exp_cnt[0]));
            void'(exp_tx.pop_front());
            void'(exp_done.pop_front());
            void'(exp_cnt.pop_front());
            if (scramble) begin
                div_i       = 16'($urandom_range(0, 7));
                data_bits_i = 4'($urandom_range(0, 15));
                parity_i    = 3'($urandom_range(0, 7));
                stop_bits_i = 1'($urandom_range(0, 1));
            end
            i++;
        end
        tick();
        check({tag, " done pulse"}, 32'(done_o), 32'd1);
        check({tag, " line idle"}, 32'(tx_o), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int div, input int nbits, input int par,
                             input bit stop2, input int data, input bit scramble);
        exp_tx.delete();
        exp_done.delete();
        exp_cnt.delete();
        set_cfg(div, nbits, par, stop2);
        append_frame(div, nbits, par, stop2, data & 'h1FF, 1'b1, 0);
        push(tag, data);
        wait_start(tag);
        compare_stream(tag, scramble);
        tick();
        check({tag, " done clears"}, 32'(done_o), 32'd0);
        check({tag, " not busy"}, 32'(busy_o), 32'd0);
    endtask

    int words[fifo_els_lp + 2];
    int w;

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b1;
        data_i  = 9'h0AA;
        break_i = 1'b0;
        set_cfg(4, 8, 0, 1'b0);
        repeat (3) tick();
        check("reset tx_o", 32'(tx_o), 32'd1);
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset done_o", 32'(done_o), 32'd0);
        check("reset fifo_count_o", 32'(fifo_count_o), 32'd0);
        check("reset ready_and_o", 32'(ready_and_o), 32'd0);
        reset_i = 1'b0;
        v_i     = 1'b0;
        tick();
        check("post-reset ready_and_o", 32'(ready_and_o), 32'd1);
        check("post-reset fifo_count_o", 32'(fifo_count_o), 32'd0);

        // Directed frame formats.
        run_frame("8N1 div4 0x55", 4, 8, 0, 1'b0, 'h55, 1'b0);
        run_frame("7E2 div3 0x41", 3, 7, 1, 1'b1, 'h41, 1'b0);
        run_frame("7O2 div3 0x41", 3, 7, 2, 1'b1, 'h41, 1'b0);
        run_frame("9M1 div2 0x1FF", 2, 9, 3, 1'b0, 'h1FF, 1'b0);
        run_frame("5S1 div2 0x3F", 2, 5, 4, 1'b0, 'h3F, 1'b0);
        run_frame("div0 8N1", 0, 8, 0, 1'b0, 'h0C3, 1'b0);
        run_frame("bits clamp low", 2, 2, 1, 1'b0, 'h1B6, 1'b0);
        run_frame("bits clamp high", 1, 15, 2, 1'b1, 'h12D, 1'b0);
        run_frame("parity code 6", 2, 8, 6, 1'b0, 'h0F0, 1'b0);

        // Randomized frames with configuration churn once each frame has started.
        for (int r = 0; r < 12; r++) begin
            run_frame($sformatf("rand %0d", r), $urandom_range(0, 4), $urandom_range(3, 11),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 511), 1'b1);
        end

        // Break while idle with one word queued.
        w = $urandom_range(0, 511);
        set_cfg(5, 8, 0, 1'b0);
        break_i = 1'b1;
        v_i     = 1'b1;
        data_i  = 9'(w);
        tick();
        v_i = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            check($sformatf("break low %0d", i), 32'(tx_o), 32'd0);
            if (i == 50) begin
                check("break fifo held", 32'(fifo_count_o), 32'd1);
                check("break busy", 32'(busy_o), 32'd1);
            end
            if (i == 100) break_i = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("break guard %0d", i), 32'(tx_o), 32'd1);
            tick();
        end
        exp_tx.delete();
        exp_done.delete();
        exp_cnt.delete();
        append_frame(5, 8, 0, 1'b0, w, 1'b1, 0);
        compare_stream("after break", 1'b0);
        tick();

        // Fill the FIFO behind a break, then drain back-to-back at div=1.
        set_cfg(1, 8, 0, 1'b0);
        break_i = 1'b1;
        tick();
        for (int k = 0; k < fifo_els_lp + 2; k++) begin
            words[k] = $urandom_range(0, 511);
            v_i      = 1'b1;
            data_i   = 9'(words[k]);
            check($sformatf("fill ready %0d", k), 32'(ready_and_o), (k < fifo_els_lp) ? 32'd1 : 32'd0);
            tick();
        end
        v_i = 1'b0;
        check("fill count", 32'(fifo_count_o), 32'(fifo_els_lp));
        exp_tx.delete();
        exp_done.delete();
        exp_cnt.delete();
        for (int k = 0; k < fifo_els_lp; k++)
            append_frame(1, 8, 0, 1'b0, words[k], k == 0, fifo_els_lp - 1 - k);
        break_i = 1'b0;
        tick();
        check("b2b guard high", 32'(tx_o), 32'd1);
        tick();
        compare_stream("b2b", 1'b0);
        tick();
        check("b2b drained", 32'(busy_o), 32'd0);

        // Reset in the middle of a data bit with words still queued.
        w = $urandom_range(0, 511);
        exp_tx.delete();
        exp_done.delete();
        exp_cnt.delete();
        set_cfg(4, 8, 0, 1'b0);
        append_frame(4, 8, 0, 1'b0, w, 1'b1, 0);
        push("reset frame", w);
        wait_start("reset frame");
        v_i    = 1'b1;
        data_i = 9'h123;
        tick();
        data_i = 9'h0ED;
        tick();
        v_i = 1'b0;
        repeat (12) tick();
        check("pre-reset data bit 2", 32'(tx_o), 32'(exp_tx[14]));
        check("pre-reset count", 32'(fifo_count_o), 32'd2);
        reset_i = 1'b1;
        tick();
        check("mid-frame reset tx_o", 32'(tx_o), 32'd1);
        check("mid-frame reset count", 32'(fifo_count_o), 32'd0);
        check("mid-frame reset ready", 32'(ready_and_o), 32'd0);
        check("mid-frame reset done", 32'(done_o), 32'd0);
        check("mid-frame reset busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;
        tick();
        check("after reset ready", 32'(ready_and_o), 32'd1);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("after reset tx %0d", i), 32'(tx_o), 32'd1);
            check($sformatf("after reset done %0d", i), 32'(done_o), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
